// File: rtl/freq_bcd_conv.sv
// -----------------------------------------------------------------------------
// freq_bcd_conv
//
// Sequential binary-to-BCD converter sitting between the frequency counter's
// latched count and the 7-segment digit decoders. A count accepted on start_i
// is converted by shift-and-add-3 (double dabble), one input bit per clock.
// Four saturated decimal digits plus an overflow flag are presented from
// registers and held stable until the next conversion completes.
//
// Optional feature macro: FREQ_BCD_BLANK_EN
//   defined   -> blank_o (registered leading-zero blank mask) is present.
//   undefined -> blank_o and its logic are absent.
//
// Handshake: start_i is a request that is taken only while busy_o=0; a
//   request seen while busy_o=1 (SHIFT or FINISH) is dropped, not queued.
//   din_i is sampled on the accepting edge only. done_o pulses for exactly
//   one cycle when bcd*_o/ovf_o (and blank_o) carry the new result; busy_o
//   falls on that same edge, so a start_i held in the done cycle is accepted.
//
// Ports:
//   clk           conversion clock
//   rst           asynchronous, active-low reset
//   start_i       conversion request
//   din_i         unsigned binary count, WIDTH bits
//   busy_o        conversion in progress
//   done_o        one-cycle pulse, new digits valid
//   bcd0_o..bcd3_o decimal digits, units to thousands (always 0..9)
//   ovf_o         input exceeded 9999, digits saturated to 9999
//   blank_o       leading-zero blank mask, bit i for bcd i (macro only)
//   dbg_state_o   current FSM state (0 IDLE, 1 SHIFT, 2 FINISH)
// -----------------------------------------------------------------------------
module freq_bcd_conv #(
   parameter int WIDTH = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [3:0]       bcd0_o,
   output logic [3:0]       bcd1_o,
   output logic [3:0]       bcd2_o,
   output logic [3:0]       bcd3_o,
   output logic             ovf_o,
`ifdef FREQ_BCD_BLANK_EN
   output logic [3:0]       blank_o,
`endif
   output logic [1:0]       dbg_state_o
);

   // ceil(WIDTH*log10(2)) decimal digits are needed to hold any WIDTH-bit
   // value. At least five are kept so the overflow slice above the
   // thousands digit is never empty.
   localparam int NDIG    = (WIDTH * 30103 + 99999) / 100000;
   localparam int ACC_DIG = (NDIG < 5) ? 5 : NDIG;
   localparam int ACC_W   = ACC_DIG * 4;
   localparam int CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   sr_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [3:0]         bcd0_q, bcd1_q, bcd2_q, bcd3_q;
   logic               ovf_q;

   logic [ACC_W-1:0]   acc_add3;
   logic [ACC_W-1:0]   acc_d;
   logic [WIDTH-1:0]   sr_d;
   logic               ovf_d;

   // Add-3 correction on every digit >= 5, then one left shift of the
   // combined {acc, sr} so the next input bit (MSB first) enters acc LSB.
   always_comb begin
      acc_add3 = acc_q;
      for (int i = 0; i < ACC_DIG; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_add3[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      {acc_d, sr_d} = {acc_add3, sr_q} << 1;
   end

   // Anything above the thousands digit means the count exceeds 9999.
   assign ovf_d = |acc_q[ACC_W-1:16];

`ifdef FREQ_BCD_BLANK_EN
   logic [3:0] blank_q;
   logic [3:0] blank_d;

   // Blank leading zeros from the thousands digit down; units never blank.
   // A saturated display shows all four nines, so nothing blanks.
   always_comb begin
      blank_d    = 4'b0000;
      if (!ovf_d) begin
         blank_d[3] = (acc_q[15:12] == 4'd0);
         blank_d[2] = blank_d[3] && (acc_q[11:8] == 4'd0);
         blank_d[1] = blank_d[2] && (acc_q[7:4]  == 4'd0);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd0_q  <= 4'd0;
         bcd1_q  <= 4'd0;
         bcd2_q  <= 4'd0;
         bcd3_q  <= 4'd0;
         ovf_q   <= 1'b0;
`ifdef FREQ_BCD_BLANK_EN
         blank_q <= 4'b1110;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  sr_q    <= din_i;
                  acc_q   <= '0;
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  busy_q  <= 1'b1;
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               acc_q <= acc_d;
               sr_q  <= sr_d;
               if (cnt_q == '0) begin
                  state_q <= S_FINISH;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_FINISH: begin
               ovf_q   <= ovf_d;
               bcd0_q  <= ovf_d ? 4'd9 : acc_q[3:0];
               bcd1_q  <= ovf_d ? 4'd9 : acc_q[7:4];
               bcd2_q  <= ovf_d ? 4'd9 : acc_q[11:8];
               bcd3_q  <= ovf_d ? 4'd9 : acc_q[15:12];
`ifdef FREQ_BCD_BLANK_EN
               blank_q <= blank_d;
`endif
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign bcd0_o      = bcd0_q;
   assign bcd1_o      = bcd1_q;
   assign bcd2_o      = bcd2_q;
   assign bcd3_o      = bcd3_q;
   assign ovf_o       = ovf_q;
   assign dbg_state_o = state_q;
`ifdef FREQ_BCD_BLANK_EN
   assign blank_o     = blank_q;
`endif

endmodule

// File: doc/freq_bcd_conv.md
# freq_bcd_conv

Sequential binary-to-BCD converter between the frequency counter's latched count and the 7-segment digit decoders. It accepts a binary count on a start strobe and converts it by shift-and-add-3 (double dabble), one bit per clock. It presents four saturated decimal digits plus an overflow flag, and holds them stable until the next conversion completes.

## Interface
- WIDTH, 21: binary input width; internal BCD accumulator holds ceil(WIDTH·log10(2)) digits (7 for 21).
- clk  input  1  conversion clock (system clock domain).
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request conversion of din; honoured only when busy=0.
- din  input  WIDTH  unsigned binary count, sampled on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are valid.
- bcd0..bcd3  output  4 each  decimal digits, units to thousands.
- ovf  output  1  input exceeded 9999; digits saturated.
- blank  output  4  leading-zero blank mask, bit i ↔ bcd i. Present only with FREQ_BCD_BLANK_EN.

## Operation
- FSM states: IDLE, SHIFT, FINISH.
- IDLE: busy=0. On start=1, load shift register ← din, BCD accumulator ← 0, bit counter ← WIDTH-1, go to SHIFT.
- SHIFT: each cycle, every accumulator digit ≥5 gets +3, then {acc, sr} shifts left by 1, so din MSB enters acc LSB. Both happen in the same cycle. Counter decrements; after the WIDTH-th shift, go to FINISH.
- FINISH: compute ovf = any accumulator digit above bcd3 nonzero.
  - If ovf=1: bcd3..bcd0 ← 9,9,9,9.
  - If ovf=0: bcd3..bcd0 ← accumulator digits 3..0.
  - Assert done for this cycle; return to IDLE.
- start while busy=1 or in FINISH: ignored, not queued. din changes after acceptance have no effect.
- Output registers update only in FINISH and hold otherwise.
- Reset (any time, including mid-conversion): state IDLE, busy=0, done=0, bcd0..bcd3=0, ovf=0, blank=4'b1110, internal registers cleared. The aborted conversion produces no done.
- All digit values are always 0–9; no code 10–15 ever appears on bcd*.

## Timing
- Start accepted at edge E0. busy=1 from E0 through the edge after E(WIDTH).
- Shifts occur at edges E1..E(WIDTH).
- Outputs and done update at edge E(WIDTH+1): latency WIDTH+1 cycles, 22 for default.
- done is high exactly one cycle; busy falls at the same edge done rises.
- A start asserted in the cycle done is high is accepted (back-to-back). Minimum period is WIDTH+2 cycles per conversion.
- Outputs are glitch-free registered values, safe for direct use by combinational segment decoders.

## Configuration
- FREQ_BCD_BLANK_EN defined: blank is registered and updated in FINISH together with the digits.
  - blank[3]=1 iff bcd3=0.
  - blank[2]=1 iff bcd3=bcd2=0.
  - blank[1]=1 iff bcd3..bcd1=0.
  - blank[0] is always 0.
  - When ovf=1, blank=0000.
  - Reset value 4'b1110.
- Not defined: blank port and its logic are absent. Downstream displays all four digits including leading zeros.

## Test plan
- din=1234, start pulse in IDLE → done exactly 22 cycles later. bcd3..0=1,2,3,4, ovf=0, blank=0000; busy high for the 22 cycles between.
- din=0, then din=9999, then din=10000 back-to-back (start in each done cycle):
  - din=0 → 0,0,0,0, ovf=0, blank=1110.
  - din=9999 → 9,9,9,9, ovf=0.
  - din=10000 → 9,9,9,9, ovf=1.
- din=2097151 (all ones) → 9,9,9,9, ovf=1, blank=0000; no digit outside 0–9 observed on any cycle.
- din=50 converting, second start with din=7 at cycle 5 → ignored. Result 0,0,5,0 with blank=1100; exactly one done.
- din=4321 started, rst asserted low at cycle 10 → outputs immediately 0, busy=0, blank=1110; no done. After release, start with din=88 → 0,0,8,8.
- Build without FREQ_BCD_BLANK_EN, rerun first scenario → identical digits and timing; blank port absent.
